// File: rtl/psum_wb_pkg.sv
// ============================================================================
// Module     : psum_wb_pkg
// Description: Shared types and default sizes for the psum writeback stage.
// Revision   : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package psum_wb_pkg;

   localparam int DEFAULT_PSUM_BW = 16;
   localparam int DEFAULT_COL     = 8;
   localparam int DEFAULT_ADDR_W  = 11;
   localparam int ROW_W           = DEFAULT_PSUM_BW * DEFAULT_COL;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } wb_state_t;

endpackage

`default_nettype wire

// File: rtl/psum_writeback_if.sv
// ============================================================================
// Module     : psum_writeback_if
// Description: OFIFO pop port and psum SRAM write port of the writeback stage.
// Revision   : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface psum_writeback_if #(
   parameter int PSUM_BW = 16,
   parameter int COL     = 8,
   parameter int ADDR_W  = 11
);

   logic                     ofifo_valid;
   logic [PSUM_BW*COL-1:0]   ofifo_rdata;
   logic                     ofifo_rd;
   logic                     sram_stall;
   logic                     sram_cen_n;
   logic                     sram_wen_n;
   logic [ADDR_W-1:0]        sram_addr;
   logic [PSUM_BW*COL-1:0]   sram_wdata;

   // master = writeback stage, slave = OFIFO/SRAM environment
   modport master (
      input  ofifo_valid, ofifo_rdata, sram_stall,
      output ofifo_rd, sram_cen_n, sram_wen_n, sram_addr, sram_wdata
   );

   modport slave (
      output ofifo_valid, ofifo_rdata, sram_stall,
      input  ofifo_rd, sram_cen_n, sram_wen_n, sram_addr, sram_wdata
   );

endinterface

`default_nettype wire

// File: rtl/psum_writeback_addr_cnt.sv
// ============================================================================
// Module     : wb_addr_cnt
// Description: Loadable wrap-around write pointer paired with a remaining-rows
//              down-counter.
// Revision   : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module wb_addr_cnt #(
   parameter int ADDR_W = 11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W-1:0] count,
   input  logic              inc,
   output logic [ADDR_W-1:0] wr_ptr,
   output logic [ADDR_W-1:0] remaining,
   output logic              last
);

   // wr_ptr wraps naturally modulo 2^ADDR_W
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         remaining <= '0;
      end else if (load) begin
         wr_ptr    <= base;
         remaining <= count;
      end else if (inc) begin
         wr_ptr    <= wr_ptr + ADDR_W'(1);
         remaining <= remaining - ADDR_W'(1);
      end
   end

   assign last = (remaining == ADDR_W'(1));

endmodule

`default_nettype wire

// File: rtl/psum_writeback.sv
// ============================================================================
// Module     : psum_writeback
// Description: Drains psum rows from the corelet OFIFO into consecutive psum
//              SRAM addresses and pulses done after a programmed row count.
//              Optional macro PSUM_WB_PERF_EN adds the stall_cnt output.
// Revision   : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module psum_writeback
   import psum_wb_pkg::*;
#(
   parameter int PSUM_BW = DEFAULT_PSUM_BW,
   parameter int COL     = DEFAULT_COL,
   parameter int ADDR_W  = DEFAULT_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] num_rows,
   psum_writeback_if.master  bus,
   output logic              busy,
`ifdef PSUM_WB_PERF_EN
   output logic [31:0]       stall_cnt,
`endif
   output logic              done
);

   wb_state_t         state;
   logic              pop;
   logic              load;
   logic              last;
   logic              last_pop;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] remaining;

   assign load = start && (state == IDLE);
   assign pop  = (state == DRAIN) && bus.ofifo_valid && !bus.sram_stall
                 && (remaining != '0);
   assign bus.ofifo_rd = pop;

   wb_addr_cnt #(
      .ADDR_W (ADDR_W)
   ) u_addr_cnt (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .base      (base_addr),
      .count     (num_rows),
      .inc       (pop),
      .wr_ptr    (wr_ptr),
      .remaining (remaining),
      .last      (last)
   );

   // last_pop marks the cycle the final row is on the SRAM port; DONE follows it
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         last_pop <= 1'b0;
      end else begin
         last_pop <= pop && last;
         case (state)
            IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (num_rows == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (last_pop) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.sram_cen_n <= 1'b1;
         bus.sram_wen_n <= 1'b1;
         bus.sram_addr  <= '0;
         bus.sram_wdata <= '0;
      end else begin
         bus.sram_cen_n <= !pop;
         bus.sram_wen_n <= !pop;
         if (pop) begin
            bus.sram_addr  <= wr_ptr;
            bus.sram_wdata <= bus.ofifo_rdata;
         end
      end
   end

`ifdef PSUM_WB_PERF_EN
   always_ff @(posedge clk) begin
      if (reset || load) begin
         stall_cnt <= '0;
      end else if ((state == DRAIN) && bus.ofifo_valid && bus.sram_stall
                   && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_psum_writeback.sv
// ============================================================================
// Module     : tb_psum_writeback
// Description: Directed self-checking bench for psum_writeback with an OFIFO
//              model; honours PSUM_WB_PERF_EN.
// Revision   : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_psum_writeback;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [10:0] base_addr;
   logic [10:0] num_rows;
   logic        busy;
   logic        done;
`ifdef PSUM_WB_PERF_EN
   logic [31:0] stall_cnt;
`endif

   always #5 clk = ~clk;

   psum_writeback_if #(.PSUM_BW(16), .COL(8), .ADDR_W(11)) bus ();

   psum_writeback #(
      .PSUM_BW (16),
      .COL     (8),
      .ADDR_W  (11)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .base_addr (base_addr),
      .num_rows  (num_rows),
      .bus       (bus),
      .busy      (busy),
`ifdef PSUM_WB_PERF_EN
      .stall_cnt (stall_cnt),
`endif
      .done      (done)
   );

   int            n_checks = 0;
   int            n_fails  = 0;
   int            cyc      = 0;
   int            start_cyc, n_pop, n_done, done_cyc, first_wr, last_wr;
   int            n_stall_pop, n_wen_bad;
   logic [127:0]  fifo [$];
   logic [10:0]   obs_a [$];
   logic [127:0]  obs_d [$];
   logic [10:0]   exp_a [5];

   function automatic logic [127:0] row(input int k);
      row = {4{32'hD000_0000 + 32'(k)}};
   endfunction

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive_fifo();
      bus.ofifo_valid = (fifo.size() != 0);
      bus.ofifo_rdata = (fifo.size() != 0) ? fifo[0] : '0;
   endtask

   // observe mid-cycle, then retire the popped row just after the edge
   task automatic tick();
      logic pop_now;
      @(negedge clk);
      cyc++;
      pop_now = bus.ofifo_rd;
      if (pop_now) n_pop++;
      if (pop_now && bus.sram_stall) n_stall_pop++;
      if (!bus.sram_cen_n) begin
         obs_a.push_back(bus.sram_addr);
         obs_d.push_back(bus.sram_wdata);
         if (first_wr < 0) first_wr = cyc;
         last_wr = cyc;
         if (bus.sram_wen_n) n_wen_bad++;
      end
      if (done) begin
         n_done++;
         done_cyc = cyc;
      end
      @(posedge clk);
      #1;
      if (pop_now && fifo.size() != 0) void'(fifo.pop_front());
      drive_fifo();
   endtask

   task automatic clear_obs();
      obs_a.delete();
      obs_d.delete();
      n_pop = 0; n_done = 0; done_cyc = -1; first_wr = -1; last_wr = -1;
      n_stall_pop = 0; n_wen_bad = 0;
   endtask

   task automatic run_job(input logic [10:0] base, input logic [10:0] num,
                          input logic [15:0] stall_mask, input int extra_start_at);
      clear_obs();
      base_addr = base;
      num_rows  = num;
      start     = 1'b1;
      tick();
      start_cyc = cyc;
      start     = 1'b0;
      for (int jc = 1; jc < 100 && n_done == 0; jc++) begin
         bus.sram_stall = (jc < 16) ? stall_mask[jc] : 1'b0;
         start          = (jc == extra_start_at);
         tick();
      end
      start          = 1'b0;
      bus.sram_stall = 1'b0;
      if (n_done == 0) check("job_timeout", 128'd0, 128'd1);
   endtask

   task automatic check_reset_state(input string pfx);
      check({pfx, "_ofifo_rd"}, 128'(bus.ofifo_rd),   128'd0);
      check({pfx, "_cen_n"},    128'(bus.sram_cen_n), 128'd1);
      check({pfx, "_wen_n"},    128'(bus.sram_wen_n), 128'd1);
      check({pfx, "_addr"},     128'(bus.sram_addr),  128'd0);
      check({pfx, "_wdata"},    bus.sram_wdata,       128'd0);
      check({pfx, "_busy"},     128'(busy),           128'd0);
      check({pfx, "_done"},     128'(done),           128'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; base_addr = '0; num_rows = '0;
      bus.sram_stall = 1'b0;
      clear_obs();
      drive_fifo();
      repeat (2) tick();
      check_reset_state("rst");
      reset = 1'b0;
      tick();

      // abandon an 8-row job after 3 pops
      for (int k = 0; k < 8; k++) fifo.push_back(row(k));
      drive_fifo();
      clear_obs();
      base_addr = 11'h100; num_rows = 11'd8; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 20 && n_pop < 3; i++) tick();
      check("t1_pops_before_reset", 128'(n_pop), 128'd3);
      reset = 1'b1;
      tick();
      check_reset_state("t1_midrst");
      reset = 1'b0;
      fifo.delete();
      drive_fifo();
      tick();

      // 4 rows back to back
      for (int k = 0; k < 4; k++) fifo.push_back(row(8'h20 + k));
      drive_fifo();
      run_job(11'h010, 11'd4, 16'h0000, -1);
      exp_a = '{11'h010, 11'h011, 11'h012, 11'h013, 11'h000};
      check("t2_pops",   128'(n_pop),       128'd4);
      check("t2_writes", 128'(obs_a.size()), 128'd4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t2_addr%0d", i), 128'(obs_a[i]), 128'(exp_a[i]));
         check($sformatf("t2_data%0d", i), obs_d[i], row(8'h20 + i));
      end
      check("t2_first_wr", 128'(first_wr - start_cyc), 128'd2);
      check("t2_last_wr",  128'(last_wr - start_cyc),  128'd5);
      check("t2_done_at",  128'(done_cyc - start_cyc), 128'd6);
      check("t2_wen",      128'(n_wen_bad),            128'd0);
      tick();
      check("t2_busy_after", 128'(busy), 128'd0);
      check("t2_fifo_left",  128'(fifo.size()), 128'd0);

      // same job with stall on job cycles 2 and 3
      for (int k = 0; k < 4; k++) fifo.push_back(row(8'h30 + k));
      drive_fifo();
      run_job(11'h010, 11'd4, 16'b0000_0000_0000_1100, -1);
      check("t3_pops",       128'(n_pop),        128'd4);
      check("t3_stall_pops", 128'(n_stall_pop),  128'd0);
      check("t3_writes",     128'(obs_a.size()), 128'd4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t3_addr%0d", i), 128'(obs_a[i]), 128'(exp_a[i]));
         check($sformatf("t3_data%0d", i), obs_d[i], row(8'h30 + i));
      end
      check("t3_first_wr", 128'(first_wr - start_cyc), 128'd2);
      check("t3_last_wr",  128'(last_wr - start_cyc),  128'd7);
      check("t3_done_at",  128'(done_cyc - start_cyc), 128'd8);
      tick();
`ifdef PSUM_WB_PERF_EN
      check("t3_stall_cnt", 128'(stall_cnt), 128'd2);
`endif

      // address wrap, plus a start issued during the DONE cycle
      for (int k = 0; k < 5; k++) fifo.push_back(row(8'h40 + k));
      drive_fifo();
      run_job(11'h7FE, 11'd4, 16'h0000, 6);
      exp_a = '{11'h7FE, 11'h7FF, 11'h000, 11'h001, 11'h000};
      check("t4_writes", 128'(obs_a.size()), 128'd4);
      for (int i = 0; i < 4; i++)
         check($sformatf("t4_addr%0d", i), 128'(obs_a[i]), 128'(exp_a[i]));
      repeat (3) tick();
      check("t4_busy_after", 128'(busy),        128'd0);
      check("t4_pops",       128'(n_pop),       128'd4);
      check("t4_fifo_left",  128'(fifo.size()), 128'd1);
      fifo.delete();
      drive_fifo();

      // zero-row job
      fifo.push_back(row(8'h50));
      fifo.push_back(row(8'h51));
      drive_fifo();
      run_job(11'h055, 11'd0, 16'h0000, -1);
      check("t5_done_at",   128'(done_cyc - start_cyc), 128'd1);
      check("t5_pops",      128'(n_pop),                128'd0);
      check("t5_writes",    128'(obs_a.size()),         128'd0);
      check("t5_fifo_left", 128'(fifo.size()),          128'd2);
      fifo.delete();
      drive_fifo();
      tick();

      // 6 rows queued, 5 requested, second start mid-job
      for (int k = 0; k < 6; k++) fifo.push_back(row(8'h60 + k));
      drive_fifo();
      run_job(11'h200, 11'd5, 16'h0000, 3);
      check("t6_pops",      128'(n_pop),        128'd5);
      check("t6_writes",    128'(obs_a.size()), 128'd5);
      check("t6_last_addr", 128'(obs_a[4]),     128'h204);
      check("t6_last_data", obs_d[4],           row(8'h64));
      check("t6_done_cnt",  128'(n_done),       128'd1);
      repeat (3) tick();
      check("t6_pops_after", 128'(n_pop),       128'd5);
      check("t6_fifo_left",  128'(fifo.size()), 128'd1);
      check("t6_fifo_head",  fifo[0],           row(8'h65));
      check("t6_busy_after", 128'(busy),        128'd0);
`ifdef PSUM_WB_PERF_EN
      check("t6_stall_cnt", 128'(stall_cnt), 128'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

`default_nettype wire
